i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

- Queues I2C single-byte transactions from a host-side valid/ready command port.
- Issues them one at a time to `i2c_master` through its `newd`/`addr`/`op`/`din` inputs.
- Collects `dout`/`ack_err`/`done` into a valid/ready response port.
- Sits directly upstream of `i2c_master`: it provides command buffering, newd pulse discipline, a transaction timeout and optional NACK retry.

## Interface
- `CMD_DEPTH`, 4: command FIFO depth; power of two, 2..16.
- `TIMEOUT_CYC`, 16384: clk cycles allowed from newd pulse to master done; 16-bit counter.
- `MAX_RETRY`, 2: extra attempts after a NACK (only with `I2C_SEQ_RETRY_EN`).
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-low.
- `cmd_valid  in  1`: command offered.
- `cmd_ready  out  1`: FIFO not full.
- `cmd_addr  in  7`: 7-bit slave address.
- `cmd_op  in  1`: 0 = write, 1 = read.
- `cmd_wdata  in  8`: write byte (ignored for reads).
- `rsp_valid  out  1`: response held.
- `rsp_ready  in  1`: response consumed.
- `rsp_rdata  out  8`: read byte (0 for writes).
- `rsp_err  out  1`: NACK or timeout.
- `rsp_timeout  out  1`: timeout occurred.
- `m_newd  out  1`: to master `newd`.
- `m_addr  out  7`: to master `addr`.
- `m_op  out  1`: to master `op`.
- `m_din  out  8`: to master `din`.
- `m_dout  in  8`: from master `dout`.
- `m_busy  in  1`: from master `busy`.
- `m_ack_err  in  1`: from master `ack_err`.
- `m_done  in  1`: from master `done`.

## Operation
- FIFO word = {op, addr[6:0], wdata[7:0]}, 16 bits.
- Push happens on `cmd_valid & cmd_ready`.
- Pop happens only on the IDLE→ISSUE transition.
- States:
  - IDLE: if FIFO non-empty, `m_busy`=0 and `rsp_valid`=0 → pop head into `m_addr/m_op/m_din` regs, retry count := 0, go ISSUE.
  - ISSUE: `m_newd`=1 for exactly this one cycle; timeout counter := 0; go WAIT_DONE.
  - WAIT_DONE: counter +1 per cycle.
    - On `m_done`=1: capture `m_dout` (reads) and `m_ack_err`, then go RESP.
    - If counter reaches `TIMEOUT_CYC`-1 before `m_done`: go RESP with timeout=1.
  - RESP: load the response register: `rsp_valid`=1, `rsp_err` = ack_err | timeout, `rsp_timeout` = timeout. Go IDLE.
- Response register holds all rsp_* fields until `rsp_valid & rsp_ready`, then clears `rsp_valid`.
- A new command is never issued while a response is pending (single-entry response buffer, no overrun possible).
- `m_addr/m_op/m_din` stay stable from ISSUE until the next pop.
- `m_newd` is never asserted while `m_busy`=1; this prevents the master re-triggering on a level `newd`.
- After a timeout, IDLE blocks until `m_busy` falls, so an aborted master transaction finishes first.
- Simultaneous push and pop on a full FIFO: not possible, since `cmd_ready`=0 when full. Push while empty plus IDLE pop: the pop sees the entry the next cycle.
- Pointers wrap modulo `CMD_DEPTH`; full/empty use an extra pointer bit.
- Reset values, applied asynchronously while `rst`=0:
  - state IDLE, FIFO empty, counters 0.
  - `cmd_ready`=1 after release.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0.
  - `m_newd`=0, `m_addr`=0, `m_op`=0, `m_din`=0.
- Reset mid-transaction drops the queued and in-flight commands and produces no response. The master is reset separately.

## Timing
- Command push to `m_newd` high: 2 cycles minimum (FIFO write, IDLE pop; `m_newd` is asserted in the ISSUE cycle).
- `m_done` to `rsp_valid`: 2 cycles (WAIT_DONE sample, RESP load).
- `rsp_ready` to next `m_newd`: 2 cycles if the FIFO is non-empty and `m_busy`=0.
- All outputs are registered; no combinational path from `m_*` inputs to outputs.
- Timeout check: `m_done` and counter terminal in the same cycle → `m_done` wins; no timeout is reported.

## Configuration
- `I2C_SEQ_RETRY_EN` defined:
  - In WAIT_DONE, `m_done` with `m_ack_err`=1 and retry count < `MAX_RETRY` → retry count +1 and go WAIT_IDLE.
  - WAIT_IDLE holds until `m_busy`=0, then goes to ISSUE.
  - Only the final attempt produces a response.
  - Timeouts are never retried.
- `I2C_SEQ_RETRY_EN` undefined: no WAIT_IDLE state, no retry counter; the first NACK is reported directly.

## Structure
- Package `i2c_seq_pkg`:
  - `seq_state_t` enum: IDLE, ISSUE, WAIT_DONE, RESP, WAIT_IDLE.
  - `i2c_cmd_t` packed struct {op, addr, wdata}.
  - Constants OP_WRITE=0, OP_READ=1.
- Sub-module `i2c_seq_fifo`: synchronous FIFO of `i2c_cmd_t`, parameter DEPTH, with push/pop/full/empty. It uses the same clk/rst and is instantiated once.

## Test plan
- Write 0x50/0xA5 with a master model ACKing → one `m_newd` pulse with `m_addr`=0x50, `m_op`=0, `m_din`=0xA5; response `rsp_err`=0, `rsp_timeout`=0.
- Read 0x68 with the model returning `dout`=0x3C → `rsp_rdata`=0x3C, `rsp_err`=0.
- Push 5 commands with CMD_DEPTH=4 and the master stalled → `cmd_ready`=0 after 4 accepted; all 5 complete in order; `m_newd` never asserted while `m_busy`=1.
- NACK on address 0x11 → `rsp_err`=1. With `I2C_SEQ_RETRY_EN` and MAX_RETRY=2: exactly 3 `m_newd` pulses, then `rsp_err`=1.
- Master never asserts done, TIMEOUT_CYC=100 → `rsp_valid` 101 cycles after `m_newd`, with `rsp_err`=1 and `rsp_timeout`=1; the next command waits for `m_busy`=0.
- `rsp_ready` held 0 for 50 cycles with 2 commands queued → no second `m_newd` until the response is accepted. Assert `rst`=0 mid-WAIT_DONE → all outputs return to reset values immediately.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP,
        WAIT_IDLE
    } seq_state_t;

    // One queued single-byte transaction: {op, addr, wdata}, 16 bits.
    typedef struct packed {
        logic       op;
        logic [6:0] addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO; full/empty use an extra pointer wrap bit.
module i2c_seq_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  i2c_cmd_t din,
    input  logic     pop,
    output i2c_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    i2c_cmd_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; guarded so a stray push/pop cannot corrupt state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + ONE;
            if (pop  && !empty) rd_ptr <= rd_ptr + ONE;
        end
    end

    // Storage array carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Buffers host I2C commands and issues them one at a time to i2c_master,
// with newd pulse discipline, a transaction timeout and a single-entry
// response register. Define I2C_SEQ_RETRY_EN to retry NACKed transfers
// up to MAX_RETRY extra times.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16384,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_op,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       m_newd,
    output logic [6:0] m_addr,
    output logic       m_op,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_busy,
    input  logic       m_ack_err,
    input  logic       m_done
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    seq_state_t  state;
    logic [15:0] cnt;
    logic        timed_out;
    logic        nack;
    logic [7:0]  rdata_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    i2c_cmd_t    head;
    i2c_cmd_t    cmd_in;

`ifdef I2C_SEQ_RETRY_EN
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
    logic [3:0] retry_cnt;
`else
    logic unused_max_retry;
    assign unused_max_retry = (MAX_RETRY != 0);
`endif

    assign cmd_in    = '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    // A pending response or a still-busy master (e.g. after a timeout) blocks issue.
    assign pop       = (state == IDLE) && !fifo_empty && !m_busy && !rsp_valid;

    i2c_seq_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer FSM with registered master-side and response-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            timed_out   <= 1'b0;
            nack        <= 1'b0;
            rdata_q     <= '0;
            m_newd      <= 1'b0;
            m_addr      <= '0;
            m_op        <= 1'b0;
            m_din       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            m_newd <= 1'b0;
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        m_addr <= head.addr;
                        m_op   <= head.op;
                        m_din  <= head.wdata;
                        m_newd <= 1'b1;
`ifdef I2C_SEQ_RETRY_EN
                        retry_cnt <= '0;
`endif
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    cnt <= cnt + 16'd1;
                    // Done wins over a timeout landing in the same cycle.
                    if (m_done) begin
                        nack      <= m_ack_err;
                        timed_out <= 1'b0;
                        rdata_q   <= (m_op == OP_READ) ? m_dout : 8'h00;
`ifdef I2C_SEQ_RETRY_EN
                        if (m_ack_err && (retry_cnt < RETRY_MAX)) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            state     <= WAIT_IDLE;
                        end else begin
                            state <= RESP;
                        end
`else
                        state <= RESP;
`endif
                    end else if ((cnt + 16'd1) == TO_LAST) begin
                        nack      <= 1'b0;
                        timed_out <= 1'b1;
                        rdata_q   <= 8'h00;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= rdata_q;
                    rsp_err     <= nack | timed_out;
                    rsp_timeout <= timed_out;
                    state       <= IDLE;
                end
`ifdef I2C_SEQ_RETRY_EN
                WAIT_IDLE: begin
                    if (!m_busy) begin
                        m_newd <= 1'b1;
                        state  <= ISSUE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer with a behavioural i2c_master model.
module tb_i2c_cmd_sequencer;

`ifdef I2C_SEQ_RETRY_EN
    localparam int NACK_PULSES = 3;
`else
    localparam int NACK_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_op;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       m_newd;
    logic [6:0] m_addr;
    logic       m_op;
    logic [7:0] m_din;
    logic [7:0] m_dout;
    logic       m_busy;
    logic       m_ack_err;
    logic       m_done;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .CMD_DEPTH   (4),
        .TIMEOUT_CYC (100),
        .MAX_RETRY   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_op      (cmd_op),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .m_newd      (m_newd),
        .m_addr      (m_addr),
        .m_op        (m_op),
        .m_din       (m_din),
        .m_dout      (m_dout),
        .m_busy      (m_busy),
        .m_ack_err   (m_ack_err),
        .m_done      (m_done)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } rsp_t;

    typedef struct {
        logic [6:0] addr;
        logic       op;
        logic [7:0] din;
    } iss_t;

    rsp_t q_rsp[$];
    iss_t q_iss[$];

    int checks = 0;
    int errors = 0;

    // Master model controls (written by stimulus only).
    int   lat       = 3;
    logic stuck     = 1'b0;
    logic hold_busy = 1'b0;
    logic model_rst = 1'b0;
    // Master model state.
    int   pulses    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural i2c_master: read data = {0,addr}^0x54, NACK on address 0x11.
    initial begin : master_model
        logic       newd_s;
        logic [6:0] addr_s;
        logic [6:0] cur_addr;
        logic       in_txn;
        logic       txn_stuck;
        int         rem;
        m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_dout = 8'h00;
        in_txn = 1'b0; txn_stuck = 1'b0; rem = 0; cur_addr = '0;
        forever begin
            @(negedge clk);
            newd_s = m_newd;
            addr_s = m_addr;
            @(posedge clk);
            #1;
            m_done = 1'b0;
            if (model_rst) begin
                in_txn = 1'b0;
                m_busy = 1'b0;
                m_ack_err = 1'b0;
            end else if (newd_s) begin
                in_txn    = 1'b1;
                txn_stuck = stuck;
                rem       = lat;
                cur_addr  = addr_s;
                pulses++;
                m_busy    = 1'b1;
            end else if (in_txn) begin
                if (txn_stuck) begin
                    if (!stuck) begin
                        in_txn = 1'b0;
                        m_busy = 1'b0;
                    end
                end else if (rem == 0) begin
                    m_done    = 1'b1;
                    m_busy    = 1'b0;
                    in_txn    = 1'b0;
                    m_ack_err = (cur_addr == 7'h11);
                    m_dout    = {1'b0, cur_addr} ^ 8'h54;
                end else begin
                    rem--;
                end
            end else begin
                m_busy = hold_busy;
            end
        end
    end

    // Monitor: checks every newd pulse and every accepted response.
    initial begin : monitor
        iss_t ei;
        rsp_t er;
        forever begin
            @(negedge clk);
            if (rst && m_newd) begin
                check("newd_while_busy", m_busy, 0);
                if (q_iss.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_newd: addr 0x%0h, none expected", m_addr);
                end else begin
                    ei = q_iss.pop_front();
                    check("m_addr", m_addr, ei.addr);
                    check("m_op", m_op, ei.op);
                    check("m_din", m_din, ei.din);
                end
            end
            if (rst && rsp_valid && rsp_ready) begin
                if (q_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: rdata 0x%0h, none expected", rsp_rdata);
                end else begin
                    er = q_rsp.pop_front();
                    check("rsp_rdata", rsp_rdata, er.rdata);
                    check("rsp_err", rsp_err, er.err);
                    check("rsp_timeout", rsp_timeout, er.to);
                end
            end
        end
    end

    task automatic push(input logic op, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready_before_push", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd(input logic op, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] ex_rd, input logic ex_err, input logic ex_to,
                       input int npulse, input logic with_rsp);
        iss_t ei;
        rsp_t er;
        ei = '{addr: a, op: op, din: d};
        for (int i = 0; i < npulse; i++) q_iss.push_back(ei);
        if (with_rsp) begin
            er = '{rdata: ex_rd, err: ex_err, to: ex_to};
            q_rsp.push_back(er);
        end
        push(op, a, d);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((q_rsp.size() + q_iss.size()) != 0 && n < budget) begin
            @(negedge clk); n++;
        end
        check(name, q_rsp.size() + q_iss.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p0;
        int n;
        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_op = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_m_newd", m_newd, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_din", m_din, 0);
        @(posedge clk); #1;

        // Write 0x50/0xA5 with ACK.
        p0 = pulses;
        cmd(1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 1, 1'b1);
        drain("drain_write", 200);
        check("write_pulses", pulses - p0, 1);

        // Read 0x68 -> 0x3C.
        cmd(1'b1, 7'h68, 8'h00, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
        drain("drain_read", 200);

        // Five reads with the master held busy: FIFO fills at four.
        p0 = pulses;
        lat = 10;
        hold_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd(1'b1, 7'h20, 8'h00, 8'h74, 1'b0, 1'b0, 1, 1'b1);
        cmd(1'b1, 7'h21, 8'h00, 8'h75, 1'b0, 1'b0, 1, 1'b1);
        cmd(1'b1, 7'h22, 8'h00, 8'h76, 1'b0, 1'b0, 1, 1'b1);
        cmd(1'b1, 7'h23, 8'h00, 8'h77, 1'b0, 1'b0, 1, 1'b1);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_no_newd", pulses - p0, 0);
        hold_busy = 1'b0;
        cmd(1'b1, 7'h24, 8'h00, 8'h70, 1'b0, 1'b0, 1, 1'b1);
        drain("drain_five", 1000);
        check("five_pulses", pulses - p0, 5);
        lat = 3;

        // NACK on 0x11.
        p0 = pulses;
        cmd(1'b0, 7'h11, 8'h99, 8'h00, 1'b1, 1'b0, NACK_PULSES, 1'b1);
        drain("drain_nack", 500);
        check("nack_pulses", pulses - p0, NACK_PULSES);

        // Timeout with a master that never finishes.
        rsp_ready = 1'b0;
        stuck = 1'b1;
        p0 = pulses;
        cmd(1'b1, 7'h30, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b1);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!m_newd && n < 50);
        check("to_newd_seen", m_newd, 1);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rsp_valid && n < 300);
        check("to_latency", n, 101);
        @(posedge clk); #1;
        cmd(1'b0, 7'h31, 8'h01, 8'h00, 1'b0, 1'b0, 1, 1'b1);
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("to_blocked_by_busy", pulses - p0, 1);
        stuck = 1'b0;
        drain("drain_timeout", 300);
        check("to_pulses", pulses - p0, 2);

        // Response back-pressure for 50 cycles with two commands queued.
        rsp_ready = 1'b0;
        p0 = pulses;
        cmd(1'b0, 7'h40, 8'h01, 8'h00, 1'b0, 1'b0, 1, 1'b1);
        cmd(1'b0, 7'h41, 8'h02, 8'h00, 1'b0, 1'b0, 1, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        check("bp_one_issue", pulses - p0, 1);
        check("bp_rsp_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        drain("drain_bp", 300);
        check("bp_pulses", pulses - p0, 2);

        // Reset in the middle of WAIT_DONE.
        stuck = 1'b1;
        p0 = pulses;
        cmd(1'b1, 7'h42, 8'h03, 8'h00, 1'b0, 1'b0, 1, 1'b0);
        n = 0;
        while (pulses == p0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_m_addr", m_addr, 0);
        check("mid_rst_m_op", m_op, 0);
        check("mid_rst_m_newd", m_newd, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        q_rsp.delete();
        q_iss.delete();
        model_rst = 1'b1;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", m_busy, 0);
        cmd(1'b0, 7'h50, 8'h5A, 8'h00, 1'b0, 1'b0, 1, 1'b1);
        drain("drain_after_rst", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
